// File: rtl/gbf_if_sched_pkg.sv
// Shared class codes, class-index enum and scheduler state encodings for the
// global-buffer interface scheduler.
package gbf_if_sched_pkg;

    localparam int unsigned CFG_W  = 4;
    localparam int unsigned N_DCLS = 6;
    localparam int unsigned N_CLS  = 7;
    localparam int unsigned PERF_W = 16;

    // Data classes in round-robin order; CFG is handled outside the arbiter.
    typedef enum logic [2:0] {
        CLS_FLGWEI = 3'd0,
        CLS_WEI    = 3'd1,
        CLS_FLGACT = 3'd2,
        CLS_ACT    = 3'd3,
        CLS_FLGOFM = 3'd4,
        CLS_OFM    = 3'd5
    } cls_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_LO,
        ST_WAIT_HI
    } sched_state_e;

    localparam logic [CFG_W-1:0] CODE_CFG    = 4'd0;
    localparam logic [CFG_W-1:0] CODE_FLGWEI = 4'd8;
    localparam logic [CFG_W-1:0] CODE_WEI    = 4'd6;
    localparam logic [CFG_W-1:0] CODE_FLGACT = 4'd4;
    localparam logic [CFG_W-1:0] CODE_ACT    = 4'd2;
    localparam logic [CFG_W-1:0] CODE_FLGOFM = 4'd10;
    localparam logic [CFG_W-1:0] CODE_OFM    = 4'd11;

    function automatic logic [CFG_W-1:0] cls_code(input cls_idx_e c);
        case (c)
            CLS_FLGWEI: return CODE_FLGWEI;
            CLS_WEI:    return CODE_WEI;
            CLS_FLGACT: return CODE_FLGACT;
            CLS_ACT:    return CODE_ACT;
            CLS_FLGOFM: return CODE_FLGOFM;
            CLS_OFM:    return CODE_OFM;
            default:    return CODE_CFG;
        endcase
    endfunction

    function automatic logic cls_inbound(input cls_idx_e c);
        return (c != CLS_FLGOFM) && (c != CLS_OFM);
    endfunction

    function automatic cls_idx_e cls_next(input cls_idx_e c);
        return (c == CLS_OFM) ? CLS_FLGWEI : cls_idx_e'(c + 3'd1);
    endfunction

endpackage

// File: rtl/gbf_if_sched_if.sv
// Scheduler-side bundle: soft resets, buffer pointers, interface handshake
// and the transaction class outputs.
interface gbf_if_sched_if
    import gbf_if_sched_pkg::*;
#(
    parameter int unsigned FLG_AW = 10,
    parameter int unsigned DAT_AW = 12
) ();

    logic              Reset;
    logic              Reset_WEI;
    logic              Reset_ACT;
    logic              Reset_OFM;
    logic              CFG_Req;
    logic              OFM_Flush;
    logic              IF_Rdy;

    logic [FLG_AW-1:0] GBFFLGWEI_AddrWr;
    logic [FLG_AW-1:0] GBFFLGWEI_AddrRd;
    logic [DAT_AW-1:0] GBFWEI_AddrWr;
    logic [DAT_AW-1:0] GBFWEI_AddrRd;
    logic [FLG_AW-1:0] GBFFLGACT_AddrWr;
    logic [FLG_AW-1:0] GBFFLGACT_AddrRd;
    logic [DAT_AW-1:0] GBFACT_AddrWr;
    logic [DAT_AW-1:0] GBFACT_AddrRd;
    logic [FLG_AW-1:0] GBFFLGOFM_AddrWr;
    logic [FLG_AW-1:0] GBFFLGOFM_AddrRd;
    logic [DAT_AW-1:0] GBFOFM_AddrWr;
    logic [DAT_AW-1:0] GBFOFM_AddrRd;

    logic              IF_Req;
    logic [CFG_W-1:0]  IF_Cfg;
    logic              IF_RdWr;
    logic              Sched_Busy;

    modport slave (
        input  Reset, Reset_WEI, Reset_ACT, Reset_OFM, CFG_Req, OFM_Flush, IF_Rdy,
        input  GBFFLGWEI_AddrWr, GBFFLGWEI_AddrRd, GBFWEI_AddrWr, GBFWEI_AddrRd,
        input  GBFFLGACT_AddrWr, GBFFLGACT_AddrRd, GBFACT_AddrWr, GBFACT_AddrRd,
        input  GBFFLGOFM_AddrWr, GBFFLGOFM_AddrRd, GBFOFM_AddrWr, GBFOFM_AddrRd,
        output IF_Req, IF_Cfg, IF_RdWr, Sched_Busy
    );

    modport master (
        output Reset, Reset_WEI, Reset_ACT, Reset_OFM, CFG_Req, OFM_Flush, IF_Rdy,
        output GBFFLGWEI_AddrWr, GBFFLGWEI_AddrRd, GBFWEI_AddrWr, GBFWEI_AddrRd,
        output GBFFLGACT_AddrWr, GBFFLGACT_AddrRd, GBFACT_AddrWr, GBFACT_AddrRd,
        output GBFFLGOFM_AddrWr, GBFFLGOFM_AddrRd, GBFOFM_AddrWr, GBFOFM_AddrRd,
        input  IF_Req, IF_Cfg, IF_RdWr, Sched_Busy
    );

endinterface

// File: rtl/gbf_if_sched_rr_arb6.sv
// Six-way round-robin arbiter: ptr names the highest-priority request,
// priority descends cyclically from there.
module rr_arb6
    import gbf_if_sched_pkg::*;
(
    input  logic [N_DCLS-1:0] req,
    input  cls_idx_e          ptr,
    output logic [N_DCLS-1:0] gnt
);

    logic       found;
    logic [2:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 3'd0;
        for (int unsigned i = 0; i < N_DCLS; i++) begin
            idx = 3'(({29'd0, ptr} + i) % N_DCLS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gbf_if_sched.sv
// Global-buffer interface scheduler: picks the next transaction class from
// buffer occupancy. Define GBF_IF_SCHED_PERF_EN to add per-class grant counters.
module gbf_if_sched
    import gbf_if_sched_pkg::*;
#(
    parameter int unsigned FLG_AW = 10,
    parameter int unsigned DAT_AW = 12,
    parameter int unsigned BURST  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    gbf_if_sched_if.slave                  bus
`ifdef GBF_IF_SCHED_PERF_EN
    ,
    output logic [N_CLS-1:0][PERF_W-1:0]   Perf_Cnt
`endif
);

    localparam logic [31:0]       BURST_W  = 32'(BURST);
    localparam logic [FLG_AW-1:0] FLG_FULL = '1;
    localparam logic [DAT_AW-1:0] DAT_FULL = '1;

    logic [FLG_AW-1:0] occ_flgwei, occ_flgact, occ_flgofm;
    logic [DAT_AW-1:0] occ_wei, occ_act, occ_ofm;
    logic [N_DCLS-1:0] elig, elig_m, dgnt;
    cls_idx_e          gidx;

    sched_state_e      state_q, state_d;
    logic              if_req_q, if_req_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              rdwr_q, rdwr_d;
    logic              busy_q, busy_d;
    logic              pend_q, pend_d;
    logic              pend_eff;
    cls_idx_e          ptr_q, ptr_d;

    // Modulo subtraction makes wrapped pointers need no special case.
    assign occ_flgwei = bus.GBFFLGWEI_AddrWr - bus.GBFFLGWEI_AddrRd;
    assign occ_wei    = bus.GBFWEI_AddrWr    - bus.GBFWEI_AddrRd;
    assign occ_flgact = bus.GBFFLGACT_AddrWr - bus.GBFFLGACT_AddrRd;
    assign occ_act    = bus.GBFACT_AddrWr    - bus.GBFACT_AddrRd;
    assign occ_flgofm = bus.GBFFLGOFM_AddrWr - bus.GBFFLGOFM_AddrRd;
    assign occ_ofm    = bus.GBFOFM_AddrWr    - bus.GBFOFM_AddrRd;

    always_comb begin
        elig             = '0;
        elig[CLS_FLGWEI] = 32'(FLG_FULL - occ_flgwei) >= BURST_W;
        elig[CLS_WEI]    = 32'(DAT_FULL - occ_wei)    >= BURST_W;
        elig[CLS_FLGACT] = 32'(FLG_FULL - occ_flgact) >= BURST_W;
        elig[CLS_ACT]    = 32'(DAT_FULL - occ_act)    >= BURST_W;
        elig[CLS_FLGOFM] = (32'(occ_flgofm) >= BURST_W) || (bus.OFM_Flush && (occ_flgofm != '0));
        elig[CLS_OFM]    = (32'(occ_ofm)    >= BURST_W) || (bus.OFM_Flush && (occ_ofm != '0));
    end

    assign elig_m = elig & ~{{2{bus.Reset_OFM}}, {2{bus.Reset_ACT}}, {2{bus.Reset_WEI}}};

    rr_arb6 u_arb (
        .req (elig_m),
        .ptr (ptr_q),
        .gnt (dgnt)
    );

    always_comb begin
        gidx = CLS_FLGWEI;
        for (int unsigned i = 0; i < N_DCLS; i++) begin
            if (dgnt[i]) gidx = cls_idx_e'(3'(i));
        end
    end

    assign pend_eff = pend_q | bus.CFG_Req;

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        rdwr_d  = rdwr_q;
        pend_d  = pend_eff;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.IF_Rdy && (pend_eff || (|elig_m))) begin
                    state_d = ST_REQ;
                    if (pend_eff) begin
                        cfg_d  = CODE_CFG;
                        rdwr_d = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        cfg_d  = cls_code(gidx);
                        rdwr_d = cls_inbound(gidx);
                        ptr_d  = cls_next(gidx);
                    end
                end
            end
            ST_REQ:     state_d = ST_WAIT_LO;
            ST_WAIT_LO: if (!bus.IF_Rdy) state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (bus.IF_Rdy) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (bus.Reset) begin
            state_d = ST_IDLE;
            cfg_d   = CODE_CFG;
            rdwr_d  = 1'b1;
            pend_d  = 1'b0;
            ptr_d   = CLS_FLGWEI;
        end
        if_req_d = (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            if_req_q <= 1'b0;
            cfg_q    <= CODE_CFG;
            rdwr_q   <= 1'b1;
            busy_q   <= 1'b0;
            pend_q   <= 1'b0;
            ptr_q    <= CLS_FLGWEI;
        end else begin
            state_q  <= state_d;
            if_req_q <= if_req_d;
            cfg_q    <= cfg_d;
            rdwr_q   <= rdwr_d;
            busy_q   <= busy_d;
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.IF_Req     = if_req_q;
    assign bus.IF_Cfg     = cfg_q;
    assign bus.IF_RdWr    = rdwr_q;
    assign bus.Sched_Busy = busy_q;

`ifdef GBF_IF_SCHED_PERF_EN
    logic                           grant_w;
    logic [N_CLS-1:0]               hit;
    logic [N_CLS-1:0][PERF_W-1:0]   perf_q, perf_d;

    // A grant is exactly the IDLE->REQ edge; soft reset already forces IDLE.
    assign grant_w = (state_q == ST_IDLE) && (state_d == ST_REQ);
    assign hit     = {dgnt & {N_DCLS{grant_w && !pend_eff}}, grant_w && pend_eff};

    always_comb begin
        perf_d = perf_q;
        for (int unsigned k = 0; k < N_CLS; k++) begin
            if (hit[k] && (perf_q[k] != '1)) perf_d[k] = perf_q[k] + 16'd1;
        end
        if (bus.Reset) perf_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign Perf_Cnt = perf_q;
`endif

endmodule

// File: tb/tb_gbf_if_sched.sv
// Directed bench for gbf_if_sched: reset, CFG priority, round-robin order,
// flush, wrap-around eligibility, per-class masks and mid-transaction soft reset.
module tb_gbf_if_sched;
    import gbf_if_sched_pkg::*;

    localparam int unsigned FLG_AW = 10;
    localparam int unsigned DAT_AW = 12;
    localparam int unsigned BURST  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gbf_if_sched_if #(.FLG_AW(FLG_AW), .DAT_AW(DAT_AW)) bus ();

`ifdef GBF_IF_SCHED_PERF_EN
    logic [N_CLS-1:0][PERF_W-1:0] perf_cnt;
`endif

    gbf_if_sched #(.FLG_AW(FLG_AW), .DAT_AW(DAT_AW), .BURST(BURST)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef GBF_IF_SCHED_PERF_EN
        ,
        .Perf_Cnt (perf_cnt)
`endif
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Inbound buffers full (free 0), outbound buffers empty, no flush.
    task automatic set_blocked();
        bus.GBFFLGWEI_AddrWr = 10'h3FF; bus.GBFFLGWEI_AddrRd = '0;
        bus.GBFWEI_AddrWr    = 12'hFFF; bus.GBFWEI_AddrRd    = '0;
        bus.GBFFLGACT_AddrWr = 10'h3FF; bus.GBFFLGACT_AddrRd = '0;
        bus.GBFACT_AddrWr    = 12'hFFF; bus.GBFACT_AddrRd    = '0;
        bus.GBFFLGOFM_AddrWr = '0;      bus.GBFFLGOFM_AddrRd = '0;
        bus.GBFOFM_AddrWr    = '0;      bus.GBFOFM_AddrRd    = '0;
        bus.OFM_Flush        = 1'b0;
    endtask

    task automatic set_empty();
        bus.GBFFLGWEI_AddrWr = '0; bus.GBFFLGWEI_AddrRd = '0;
        bus.GBFWEI_AddrWr    = '0; bus.GBFWEI_AddrRd    = '0;
        bus.GBFFLGACT_AddrWr = '0; bus.GBFFLGACT_AddrRd = '0;
        bus.GBFACT_AddrWr    = '0; bus.GBFACT_AddrRd    = '0;
        bus.GBFFLGOFM_AddrWr = '0; bus.GBFFLGOFM_AddrRd = '0;
        bus.GBFOFM_AddrWr    = '0; bus.GBFOFM_AddrRd    = '0;
    endtask

    // Waits for a grant, captures it, then walks the interface through busy/idle.
    task automatic run_txn(input string tag, output logic [3:0] cfg, output logic rdwr);
        int unsigned n;
        n = 0;
        bus.IF_Rdy = 1'b1;
        while (bus.IF_Req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(bus.IF_Req), 32'd1);
        cfg  = bus.IF_Cfg;
        rdwr = bus.IF_RdWr;
        bus.IF_Rdy = 1'b0;
        tick();
        tick();
        bus.IF_Rdy = 1'b1;
        tick();
    endtask

    task automatic count_reqs(input int unsigned cycles, output int unsigned cnt);
        cnt = 0;
        for (int unsigned i = 0; i < cycles; i++) begin
            tick();
            if (bus.IF_Req === 1'b1) cnt++;
        end
    endtask

    logic [3:0]  c;
    logic        r;
    int unsigned cnt;
    logic [3:0]  exp_cfg  [7];
    logic        exp_rdwr [7];

    initial begin
        exp_cfg  = '{4'd8, 4'd6, 4'd4, 4'd2, 4'd10, 4'd11, 4'd8};
        exp_rdwr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        bus.Reset = 1'b0; bus.Reset_WEI = 1'b0; bus.Reset_ACT = 1'b0; bus.Reset_OFM = 1'b0;
        bus.CFG_Req = 1'b0; bus.OFM_Flush = 1'b0; bus.IF_Rdy = 1'b0;
        set_empty();
        tick();
        tick();
        check("rst_req",  32'(bus.IF_Req),     32'd0);
        check("rst_cfg",  32'(bus.IF_Cfg),     32'd0);
        check("rst_rdwr", 32'(bus.IF_RdWr),    32'd1);
        check("rst_busy", 32'(bus.Sched_Busy), 32'd0);
        rst = 1'b0;
        tick();

        // Empty buffers: first grant is FLGWEI.
        run_txn("first", c, r);
        check("first_cfg",  32'(c), 32'd8);
        check("first_rdwr", 32'(r), 32'd1);
        bus.IF_Rdy = 1'b0;
        tick();
        check("cfg_hold",  32'(bus.IF_Cfg),     32'd8);
        check("idle_busy", 32'(bus.Sched_Busy), 32'd0);

        // CFG beats WEI arriving in the same IDLE cycle.
        set_blocked();
        bus.GBFWEI_AddrWr = '0;
        bus.CFG_Req = 1'b1;
        bus.IF_Rdy  = 1'b1;
        tick();
        bus.CFG_Req = 1'b0;
        check("cfgwin_busy", 32'(bus.Sched_Busy), 32'd1);
        run_txn("cfgwin", c, r);
        check("cfgwin_cfg",  32'(c), 32'd0);
        check("cfgwin_rdwr", 32'(r), 32'd1);
        run_txn("weinext", c, r);
        check("weinext_cfg", 32'(c), 32'd6);
        bus.IF_Rdy = 1'b0;

        // Soft reset from IDLE clears held class code.
        bus.Reset = 1'b1;
        tick();
        bus.Reset = 1'b0;
        check("sreset_cfg",  32'(bus.IF_Cfg),  32'd0);
        check("sreset_rdwr", 32'(bus.IF_RdWr), 32'd1);

        // All six classes eligible: full round-robin lap.
        set_empty();
        bus.GBFFLGOFM_AddrWr = 10'd20;
        bus.GBFOFM_AddrWr    = 12'd100;
        for (int i = 0; i < 7; i++) begin
            run_txn("rr", c, r);
            check($sformatf("rr%0d_cfg", i),  32'(c), 32'(exp_cfg[i]));
            check($sformatf("rr%0d_rdwr", i), 32'(r), 32'(exp_rdwr[i]));
        end
        bus.IF_Rdy = 1'b0;

        // OFM below burst waits for flush.
        bus.Reset = 1'b1;
        tick();
        bus.Reset = 1'b0;
        set_blocked();
        bus.GBFOFM_AddrWr = 12'd5;
        bus.IF_Rdy = 1'b1;
        count_reqs(5, cnt);
        check("ofm5_noflush", 32'(cnt), 32'd0);
        bus.OFM_Flush = 1'b1;
        run_txn("flush", c, r);
        check("flush_cfg",  32'(c), 32'd11);
        check("flush_rdwr", 32'(r), 32'd0);
        bus.IF_Rdy = 1'b0;
        bus.OFM_Flush = 1'b0;

        // Wrapped ACT pointers, occupancy 21.
        set_blocked();
        bus.GBFACT_AddrWr = 12'h005;
        bus.GBFACT_AddrRd = 12'hFF0;
        run_txn("actwrap", c, r);
        check("actwrap_cfg",  32'(c), 32'd2);
        check("actwrap_rdwr", 32'(r), 32'd1);
        // free = 15: not eligible; free = 16: eligible.
        bus.GBFACT_AddrWr = 12'hFF0;
        bus.GBFACT_AddrRd = 12'h000;
        count_reqs(4, cnt);
        check("act_free15", 32'(cnt), 32'd0);
        bus.GBFACT_AddrWr = 12'hFEF;
        run_txn("act16", c, r);
        check("act_free16_cfg", 32'(c), 32'd2);
        bus.IF_Rdy = 1'b0;
        // Wrapped OFM pointers, occupancy exactly 16.
        set_blocked();
        bus.GBFOFM_AddrWr = 12'h003;
        bus.GBFOFM_AddrRd = 12'hFF3;
        run_txn("ofm16", c, r);
        check("ofm16_cfg",  32'(c), 32'd11);
        check("ofm16_rdwr", 32'(r), 32'd0);
        bus.IF_Rdy = 1'b0;

        // Reset_WEI masks only its own cycle; CFG_Req during a transaction is kept.
        set_blocked();
        bus.GBFWEI_AddrWr = '0;
        bus.Reset_WEI = 1'b1;
        bus.IF_Rdy = 1'b1;
        tick();
        bus.Reset_WEI = 1'b0;
        check("wei_masked", 32'(bus.IF_Req), 32'd0);
        tick();
        check("wei_unmask_req", 32'(bus.IF_Req), 32'd1);
        check("wei_unmask_cfg", 32'(bus.IF_Cfg), 32'd6);
        bus.CFG_Req = 1'b1;
        tick();
        bus.CFG_Req = 1'b0;
        set_blocked();
        bus.IF_Rdy = 1'b0;
        tick();
        bus.IF_Rdy = 1'b1;
        tick();
        run_txn("cfglatch", c, r);
        check("cfglatch_cfg", 32'(c), 32'd0);
        bus.IF_Rdy = 1'b0;

        // Soft reset in WAIT_LO with CFG pending.
        set_blocked();
        bus.GBFACT_AddrWr = '0;
        bus.IF_Rdy = 1'b1;
        tick();
        check("wlo_req", 32'(bus.IF_Req), 32'd1);
        bus.CFG_Req = 1'b1;
        tick();
        bus.CFG_Req = 1'b0;
        check("wlo_busy", 32'(bus.Sched_Busy), 32'd1);
        bus.Reset = 1'b1;
        tick();
        bus.Reset = 1'b0;
        check("wlo_rst_req",  32'(bus.IF_Req),     32'd0);
        check("wlo_rst_cfg",  32'(bus.IF_Cfg),     32'd0);
        check("wlo_rst_rdwr", 32'(bus.IF_RdWr),    32'd1);
        check("wlo_rst_busy", 32'(bus.Sched_Busy), 32'd0);
        set_blocked();
        count_reqs(5, cnt);
        check("wlo_pend_clr", 32'(cnt), 32'd0);
        bus.IF_Rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gbf_if_sched.md
GBF_IF_SCHED -- requirements
Module: gbf_if_sched

Interface
REQ-001 Parameter FLG_AW, default 10: flag-buffer address width; depth is 2^FLG_AW.
REQ-002 Parameter DAT_AW, default 12: data-buffer address width; depth is 2^DAT_AW.
REQ-003 Parameter BURST, default 16: words per interface transaction; eligibility threshold.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 Reset  in  1  synchronous soft reset of the scheduler.
REQ-007 Reset_WEI / Reset_ACT / Reset_OFM  in  1 each  per-class soft reset strobes.
REQ-008 CFG_Req  in  1  one-cycle configuration fetch request.
REQ-009 OFM_Flush  in  1  level; drain OFM/FLGOFM down to empty.
REQ-010 IF_Rdy  in  1  interface idle/ready.
REQ-011 GBFFLGWEI_AddrWr, GBFFLGWEI_AddrRd  in  FLG_AW each.
REQ-012 GBFWEI_AddrWr, GBFWEI_AddrRd  in  DAT_AW each.
REQ-013 GBFFLGACT_AddrWr, GBFFLGACT_AddrRd  in  FLG_AW each.
REQ-014 GBFACT_AddrWr, GBFACT_AddrRd  in  DAT_AW each.
REQ-015 GBFFLGOFM_AddrWr, GBFFLGOFM_AddrRd  in  FLG_AW each.
REQ-016 GBFOFM_AddrWr, GBFOFM_AddrRd  in  DAT_AW each.
REQ-017 IF_Req  out  1  one-cycle transaction pulse.
REQ-018 IF_Cfg  out  4  class code: CFG 0, FLGWEI 8, WEI 6, FLGACT 4, ACT 2, FLGOFM 10, OFM 11.
REQ-019 IF_RdWr  out  1  1 = inbound (CFG, WEI, ACT classes), 0 = outbound (OFM classes).
REQ-020 Sched_Busy  out  1  high in any state other than IDLE.

Function
REQ-021 Occupancy SHALL be (AddrWr - AddrRd) mod 2^AW; free SHALL be 2^AW - 1 - occupancy; equal addresses mean empty.
REQ-022 An inbound class SHALL be eligible when free >= BURST; an outbound class SHALL be eligible when occupancy >= BURST, or occupancy > 0 while OFM_Flush is high.
REQ-023 CFG_Req SHALL set a pending flag, cleared when CFG is granted; CFG_Req in any state SHALL be latched, never lost.
REQ-024 FSM states SHALL be IDLE, REQ, WAIT_LO, WAIT_HI.
REQ-025 IDLE -> REQ when IF_Rdy=1 and CFG is pending or any class is eligible; grant is registered on that edge.
REQ-026 REQ SHALL last exactly one cycle with IF_Req=1, then go to WAIT_LO.
REQ-027 WAIT_LO -> WAIT_HI on IF_Rdy=0; WAIT_HI -> IDLE on IF_Rdy=1; minimum grant-to-grant spacing is 4 cycles.
REQ-028 Pending CFG SHALL beat all data classes in the same cycle.
REQ-029 Data classes SHALL be round-robin in order FLGWEI, WEI, FLGACT, ACT, FLGOFM, OFM, starting after the last granted data class; CFG grants do not move the pointer.
REQ-030 IF_Cfg and IF_RdWr SHALL be updated on the grant edge and held until the next grant.
REQ-031 A Reset_WEI/ACT/OFM strobe SHALL mask its two classes from eligibility in that cycle only; an in-flight transaction SHALL complete normally.
REQ-032 Address wrap-around SHALL need no special handling beyond the modulo rule.

Reset
REQ-033 On rst: FSM=IDLE, IF_Req=0, IF_Cfg=0, IF_RdWr=1, Sched_Busy=0, CFG pending=0, RR pointer=FLGWEI.
REQ-034 Reset=1 SHALL apply the same values synchronously, with priority over all other updates, including mid-transaction.

Configuration
REQ-035 With GBF_IF_SCHED_PERF_EN defined: add output Perf_Cnt (7 x 16 bits, class order CFG..OFM); each counter increments per grant, saturates at 0xFFFF, and clears on rst/Reset.
REQ-036 Without GBF_IF_SCHED_PERF_EN: no counters and no Perf_Cnt port.

Structure
REQ-037 Class codes, the class-index enum and FSM state encodings SHALL live in a shared package, also used by the interface datapath.
REQ-038 Round-robin selection SHALL be a sub-module, rr_arb6 (6-bit request vector and pointer in, one-hot grant out).

Verification
REQ-039 Reset release, all buffers empty, IF_Rdy=1 -> one IF_Req grants FLGWEI (IF_Cfg=8, IF_RdWr=1).
REQ-040 CFG_Req and an eligible WEI in the same IDLE cycle -> CFG granted first (IF_Cfg=0); WEI granted in the next IDLE.
REQ-041 All six classes eligible, IF_Rdy toggled per transaction -> grant order 8, 6, 4, 2, 10, 11, 8.
REQ-042 OFM AddrWr=5, AddrRd=0, BURST=16 -> no grant; OFM_Flush=1 -> grant IF_Cfg=11, IF_RdWr=0.
REQ-043 ACT AddrWr=0x005, AddrRd=0xFF0 (wrapped, occupancy 21) -> free computed correctly; eligible only if free >= 16.
REQ-044 Reset asserted in WAIT_LO -> next cycle IDLE, IF_Cfg=0, pending CFG cleared, no IF_Req.
